// File: rtl/nor_logic_pipe_if.sv
// Operand/result handshake bundle for nor_logic_pipe.
// slave is the unit's view, master is the source/consumer view.
interface nor_logic_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y
    );
endinterface

// File: rtl/nor_logic_pipe.sv
// W-bit, 8-function logic unit built purely from 2-input NOR cells, STAGES-deep pipeline.
// Define NOR_LOGIC_PIPE_FLAGS_EN to add registered zero/parity outputs.
module nor_logic_bit (
    input  logic       a,
    input  logic       b,
    input  logic [7:0] sel,
    output logic       y
);
    function automatic logic nor2(input logic x, input logic z);
        return (x | z) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic and2(input logic x, input logic z);
        return nor2(nor2(x, x), nor2(z, z));
    endfunction
    function automatic logic or2(input logic x, input logic z);
        return nor2(nor2(x, z), nor2(x, z));
    endfunction

    logic [7:0] f;
    logic       na, nb, nab, xn, acc;

    always_comb begin
        na   = nor2(a, a);
        nb   = nor2(b, b);
        nab  = nor2(a, b);
        xn   = nor2(nor2(a, nab), nor2(b, nab));
        f[0] = nor2(na, nb);
        f[1] = nor2(nab, nab);
        f[2] = nor2(f[0], f[0]);
        f[3] = nab;
        f[4] = nor2(xn, xn);
        f[5] = xn;
        f[6] = na;
        f[7] = a;
        // AND-OR mux against the one-hot select
        acc = 1'b0;
        for (int k = 0; k < 8; k++) acc = or2(acc, and2(sel[k], f[k]));
        y = acc;
    end
endmodule

module nor_logic_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    nor_logic_pipe_if.slave bus,
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    output logic          zero,
    output logic          parity,
`endif
    output logic [CW-1:0] done_count
);
    function automatic logic nor2(input logic x, input logic z);
        return (x | z) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic and2(input logic x, input logic z);
        return nor2(nor2(x, x), nor2(z, z));
    endfunction

    logic [7:0]                sel;
    logic [2:0]                nop, lit;
    logic [W-1:0]              f;
    logic [STAGES:1]           vld_pipe;
    logic [STAGES:1][W-1:0]    dat_pipe;
    logic                      adv;

    // One-hot decode of op, shared by every bit slice
    always_comb begin
        sel = '0;
        lit = '0;
        for (int i = 0; i < 3; i++) nop[i] = nor2(bus.op[i], bus.op[i]);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) lit[i] = k[i] ? bus.op[i] : nop[i];
            sel[k] = and2(and2(lit[0], lit[1]), lit[2]);
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        nor_logic_bit u_bit (
            .a   (bus.a[i]),
            .b   (bus.b[i]),
            .sel (sel),
            .y   (f[i])
        );
    end

    assign adv           = bus.out_ready || !vld_pipe[STAGES];
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.y         = dat_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            dat_pipe   <= '0;
            done_count <= '0;
        end else begin
            if (adv) begin
                vld_pipe[1] <= bus.in_valid;
                dat_pipe[1] <= f;
                for (int s = 2; s <= STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    dat_pipe[s] <= dat_pipe[s-1];
                end
            end
            if (vld_pipe[STAGES] && bus.out_ready) done_count <= done_count + CW'(1);
        end
    end

`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    function automatic logic xor2(input logic x, input logic z);
        logic n, xn;
        n  = nor2(x, z);
        xn = nor2(nor2(x, n), nor2(z, n));
        return nor2(xn, xn);
    endfunction

    logic [W-1:0] last_in;
    logic         any1, par, zero_nxt, zero_q, parity_q;

    // Flags are computed from whatever is about to enter the final stage
    if (STAGES == 1) begin : g_last1
        assign last_in = f;
    end else begin : g_lastn
        assign last_in = dat_pipe[STAGES-1];
    end

    always_comb begin
        any1 = 1'b0;
        par  = 1'b0;
        for (int i = 0; i < W; i++) begin
            any1 = nor2(nor2(any1, last_in[i]), nor2(any1, last_in[i]));
            par  = xor2(par, last_in[i]);
        end
        zero_nxt = nor2(any1, any1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (adv) begin
            zero_q   <= zero_nxt;
            parity_q <= par;
        end
    end

    assign zero   = and2(zero_q, vld_pipe[STAGES]);
    assign parity = and2(parity_q, vld_pipe[STAGES]);
`endif
endmodule

// File: tb/tb_nor_logic_pipe.sv
// Directed-vector bench for nor_logic_pipe (W=8, STAGES=2, CW=4).
// Honours NOR_LOGIC_PIPE_FLAGS_EN for the zero/parity checks.
module tb_nor_logic_pipe;
    localparam int W = 8, STAGES = 2, CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] done_count;
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
    logic          zero, parity;
`endif
    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    exp1 [0:7];

    nor_logic_pipe_if #(.W(W)) bus ();

    nor_logic_pipe #(.W(W), .STAGES(STAGES), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef NOR_LOGIC_PIPE_FLAGS_EN
        .zero       (zero),
        .parity     (parity),
`endif
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [2:0] o);
        bus.in_valid = v;
        bus.a        = av;
        bus.b        = bv;
        bus.op       = o;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        step();
        chk("in_ready_in_reset", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
    endtask

    initial begin
        exp1 = '{8'h42, 8'hDB, 8'hBD, 8'h24, 8'h99, 8'h66, 8'h3C, 8'hC3};

        // reset state
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_done", 32'(done_count), 32'd0);

        // op sweep, back-to-back beats
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 8'hC3, 8'h5A, 3'(k));
            else       drive(1'b0, 8'h00, 8'h00, 3'd0);
            step();
            if (k >= 1 && k <= 8) begin
                chk($sformatf("sweep_valid_op%0d", k-1), 32'(bus.out_valid), 32'd1);
                chk($sformatf("sweep_y_op%0d", k-1), 32'(bus.y), 32'(exp1[k-1]));
            end
        end
        chk("sweep_tail_valid", 32'(bus.out_valid), 32'd0);
        chk("sweep_done", 32'(done_count), 32'd8);

        // back-pressure: 3 stalled cycles with beat 0 at the output
        do_reset();
        drive(1'b1, 8'h11, 8'h00, 3'd7); step();
        drive(1'b1, 8'h22, 8'h00, 3'd7); step();
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_first_y", 32'(bus.y), 32'h11);
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h33, 8'h00, 3'd7);
        #1;
        chk("bp_in_ready_comb", 32'(bus.in_ready), 32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("bp_stall%0d_valid", s), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_stall%0d_y", s), 32'(bus.y), 32'h11);
            chk($sformatf("bp_stall%0d_in_ready", s), 32'(bus.in_ready), 32'd0);
        end
        chk("bp_stall_done", 32'(done_count), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_y1", 32'(bus.y), 32'h22);
        chk("bp_done1", 32'(done_count), 32'd1);
        drive(1'b1, 8'h44, 8'h00, 3'd7); step();
        chk("bp_y2", 32'(bus.y), 32'h33);
        drive(1'b0, 8'h00, 8'h00, 3'd0); step();
        chk("bp_y3", 32'(bus.y), 32'h44);
        chk("bp_valid3", 32'(bus.out_valid), 32'd1);
        step();
        chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_done", 32'(done_count), 32'd4);

        // bubbles 1,0,1,0
        do_reset();
        drive(1'b1, 8'h0F, 8'hF0, 3'd3); step();
        drive(1'b0, 8'h00, 8'h00, 3'd0); step();
        chk("bub_v0", 32'(bus.out_valid), 32'd1);
        chk("bub_y0", 32'(bus.y), 32'h00);
        drive(1'b1, 8'h01, 8'h02, 3'd1); step();
        chk("bub_v1", 32'(bus.out_valid), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 3'd0); step();
        chk("bub_v2", 32'(bus.out_valid), 32'd1);
        chk("bub_y2", 32'(bus.y), 32'h03);
        step();
        chk("bub_v3", 32'(bus.out_valid), 32'd0);
        chk("bub_done", 32'(done_count), 32'd2);

        // reset with two beats in flight and a third presented on the reset edge
        do_reset();
        drive(1'b1, 8'hAA, 8'h00, 3'd7); step();
        drive(1'b1, 8'hBB, 8'h00, 3'd7); step();
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        drive(1'b1, 8'hCC, 8'h00, 3'd7); step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_done", 32'(done_count), 32'd0);
        chk("mid_y", 32'(bus.y), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("mid_flush%0d_valid", s), 32'(bus.out_valid), 32'd0);
        end

        // counter wrap: 17 transfers on a 4-bit counter
        do_reset();
        for (int j = 0; j < 17; j++) begin
            drive(1'b1, 8'(j), 8'h00, 3'd7);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0);
        step();
        chk("wrap_last_y", 32'(bus.y), 32'h10);
        chk("wrap_done16", 32'(done_count), 32'd0);
        step();
        chk("wrap_done17", 32'(done_count), 32'd1);

`ifdef NOR_LOGIC_PIPE_FLAGS_EN
        do_reset();
        chk("flag_rst_zero", 32'(zero), 32'd0);
        chk("flag_rst_parity", 32'(parity), 32'd0);
        drive(1'b1, 8'hFF, 8'hFF, 3'd4); step();
        drive(1'b1, 8'h07, 8'h00, 3'd7); step();
        chk("flag_xor_y", 32'(bus.y), 32'h00);
        chk("flag_xor_zero", 32'(zero), 32'd1);
        chk("flag_xor_parity", 32'(parity), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 3'd0); step();
        chk("flag_pass_y", 32'(bus.y), 32'h07);
        chk("flag_pass_zero", 32'(zero), 32'd0);
        chk("flag_pass_parity", 32'(parity), 32'd1);
        step();
        chk("flag_idle_zero", 32'(zero), 32'd0);
        chk("flag_idle_parity", 32'(parity), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nor_logic_pipe.md
# nor_logic_pipe

Parametrised W-bit bitwise logic unit in which every operation is built only from 2-input NOR primitives, wrapped in a STAGES-deep registered pipeline with valid/ready flow control. It generalises the single-bit NOR-built AND gate to eight selectable functions over W-bit operands. Results are registered, back-pressure is supported, and completed transfers are counted. It sits between an operand source and any result consumer in the lab datapath.

## Interface
- W, 8, operand/result width in bits (1..64)
- STAGES, 2, pipeline register stages, i.e. latency (1..4)
- CW, 16, width of the completed-transfer counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts a beat this cycle
- a  in  W  operand A
- b  in  W  operand B
- op  in  3  function select, sampled with the beat
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- y  out  W  result
- done_count  out  CW  number of completed output transfers

## Operation
- Op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A (b ignored for 6 and 7).
- Every function is a per-bit network of 2-input NOR cells only. No &, ^ or ~ operators appear in the datapath.
  - NOT x = NOR(x,x); OR = NOT NOR; AND = NOR(NOT a, NOT b); NAND = NOT AND.
  - XNOR = NOR(NOR(a,NOR(a,b)), NOR(b,NOR(a,b))); XOR = NOT XNOR.
  - op select is a NOR-built AND-OR mux.
- Result is computed combinationally at entry and captured in stage 1. Stages 2..STAGES carry data and a valid bit.
- Flow control is a global enable: `adv = out_ready | ~out_valid`.
  - in_ready = adv.
  - When adv = 1, all stages shift and stage 1 loads {in_valid, f(a,b,op)}.
  - When adv = 0, all stages hold.
- A transfer occurs on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
- done_count increments by 1 on each output transfer. It wraps from 2^CW−1 to 0.
- Bubbles (in_valid = 0 while adv = 1) propagate as invalid stages. Data in invalid stages is don't-care.

## Timing
- Reset (rst = 1 at a clock edge):
  - All stage valids, out_valid and done_count are cleared to 0.
  - y = 0.
  - in_ready reads 1 during and after reset.
- Latency is exactly STAGES cycles from input transfer to out_valid, with no stall.
- Throughput is one beat per cycle while out_ready = 1.
- Stall: when out_valid = 1 and out_ready = 0, y, out_valid and all stages hold. in_ready = 0 in the same cycle (combinational).
- Ordering: results leave in acceptance order. There is no drop and no duplication.
- Reset mid-stream discards all in-flight beats. done_count is not incremented for a beat presented on the reset cycle.
- Simultaneous output transfer and counter wrap: the counter reads 0 on the next cycle.
- y is stable whenever out_valid = 1 and out_ready = 0.

## Configuration
- NOR_LOGIC_PIPE_FLAGS_EN
  - Defined: adds outputs zero (1 bit, y == 0) and parity (1 bit, XOR-reduction of y). Both are built from NOR cells, registered alongside the final stage, qualified by out_valid, and 0 after reset.
  - Undefined: neither port exists, and behaviour is otherwise identical.

## Test plan
- W=8, STAGES=2, out_ready=1: a=0xC3, b=0x5A swept through op 0..7 on consecutive cycles.
  - Required y sequence, starting 2 cycles after the first beat: 0x42, 0xDB, 0xBD, 0x24, 0x99, 0x66, 0x3C, 0xC3.
  - done_count ends at 8.
- Back-pressure: 4 beats issued, out_ready held 0 for 3 cycles after the first out_valid.
  - in_ready = 0 throughout the stall.
  - y holds its value.
  - All 4 results emerge in order once out_ready = 1, with no loss.
- Bubbles: in_valid pattern 1,0,1,0.
  - out_valid pattern 1,0,1,0, delayed by STAGES cycles.
  - done_count = 2.
- Reset mid-stream: rst asserted for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid = 0, done_count = 0, y = 0.
  - The in-flight beats never appear at the output.
- Counter wrap with CW=4: 17 output transfers leave done_count = 1.
- With NOR_LOGIC_PIPE_FLAGS_EN defined:
  - a=0xFF, b=0xFF, op=XOR gives y=0x00, zero=1, parity=0.
  - a=0x07, op=PASS A gives parity=1, zero=0.
